fetch_stage: RTL and testbench

//  IF stage of the P5 pipeline: holds PC_F, fetches from instruction memory over a req/valid

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response handshake.
// master = fetch_stage (req, addr out); slave = memory (rdata, valid out).
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  valid
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output valid
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage. Holds PC_F, fetches over imem req/valid, loads IF/ID.
// Ports: clk, reset (async high), NPC, Stall, imem (master), PC_F, Instr_D,
// PC_D, ExcAdEL_D, Fetch_Busy (to hazard unit; no path from Stall).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_BYTES = 32'h0000_4000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          NPC,
    input  logic                 Stall,
    fetch_stage_if.master        imem,
    output logic [31:0]          PC_F,
    output logic [31:0]          Instr_D,
    output logic [31:0]          PC_D,
    output logic                 ExcAdEL_D,
    output logic                 Fetch_Busy
);

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] buf_instr;
    logic        buf_bad;

    logic [31:0] off;
    logic        bad;
    logic        rdy;
    logic [31:0] instr;
    logic        instr_bad;
    logic        avail;
    logic        capture;
    logic        advance;

    // Offset compare avoids overflow of IM_BASE + IM_BYTES.
    assign off  = PC_F - IM_BASE;
    assign bad  = (PC_F[1:0] != 2'b00) || (PC_F < IM_BASE) || (off >= IM_BYTES);
    assign rdy  = bad || imem.valid;

    assign imem.addr = PC_F;

    always_comb begin
        state_nxt  = state;
        imem.req   = 1'b0;
        Fetch_Busy = 1'b0;
        avail      = 1'b0;
        capture    = 1'b0;
        instr      = buf_instr;
        instr_bad  = buf_bad;
        unique case (state)
            FETCH: begin
                imem.req   = !bad;
                Fetch_Busy = !rdy;
                instr      = bad ? 32'h0 : imem.rdata;
                instr_bad  = bad;
                if (rdy) begin
                    avail = 1'b1;
                    // Response arrived during a stall: park it so the
                    // memory is not asked again.
                    if (Stall) begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                // Memory responses here are protocol errors and ignored.
                avail = 1'b1;
                if (!Stall) begin
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign advance = avail && !Stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_F      <= RESET_PC;
            PC_D      <= RESET_PC;
            Instr_D   <= 32'h0;
            ExcAdEL_D <= 1'b0;
            buf_instr <= 32'h0;
            buf_bad   <= 1'b0;
        end else begin
            if (capture) begin
                buf_instr <= instr;
                buf_bad   <= instr_bad;
            end
            // PC_F moves only on advance, so each instruction steps it once.
            if (advance) begin
                Instr_D   <= instr;
                PC_D      <= PC_F;
                ExcAdEL_D <= instr_bad;
                PC_F      <= NPC;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a latency-programmable
// instruction ROM model and a small NPC model (sequential, beq, bad-address).
module tb_fetch_stage;

    localparam logic [31:0] BEQ = 32'h1000_0040;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] NPC;
    logic        Stall;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic        ExcAdEL_D;
    logic        Fetch_Busy;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .NPC        (NPC),
        .Stall      (Stall),
        .imem       (imem),
        .PC_F       (PC_F),
        .Instr_D    (Instr_D),
        .PC_D       (PC_D),
        .ExcAdEL_D  (ExcAdEL_D),
        .Fetch_Busy (Fetch_Busy)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t sb[$];

    int   lat     = 0;
    int   wcnt;
    logic stray   = 1'b0;
    logic br_en   = 1'b0;
    logic bad_en  = 1'b0;
    logic chk_req = 1'b0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h3000) ? BEQ : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h3000) || (a >= 32'h7000);
    endfunction

    // Memory: valid after lat cycles of continuous request.
    always_comb begin
        imem.valid = (imem.req && (wcnt == lat)) || stray;
        imem.rdata = stray ? 32'hDEAD_BEEF : rom(imem.addr);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (!imem.req || imem.valid) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    // Next-PC logic model.
    always_comb begin
        NPC = PC_F + 32'd4;
        if (br_en && Instr_D == BEQ) NPC = PC_D + 32'h100;
        if (bad_en) begin
            if (PC_F == 32'h3000) NPC = 32'h3002;
            else if (PC_F == 32'h3002) NPC = 32'h8000;
            else NPC = 32'h3000;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_ok(input logic [31:0] pc);
        ent_t e;
        e.pc = pc;
        e.instr = rom(pc);
        e.exc = 1'b0;
        sb.push_back(e);
    endtask

    task automatic push_bad(input logic [31:0] pc);
        ent_t e;
        e.pc = pc;
        e.instr = 32'h0;
        e.exc = 1'b1;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst.pc_f", PC_F, 32'h3000);
        check("rst.pc_d", PC_D, 32'h3000);
        check("rst.instr", Instr_D, 32'h0);
        check("rst.exc", {31'h0, ExcAdEL_D}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Pops one entry per advance; gap = cycles since previous advance.
    task automatic run(input string tag, input int gap_exp, input int budget);
        int   gap;
        int   cyc;
        logic adv;
        ent_t e;
        gap = 0;
        cyc = 0;
        while (sb.size() > 0 && cyc < budget) begin
            @(negedge clk);
            adv = !Stall && !Fetch_Busy;
            if (chk_req) begin
                check({tag, ".req"}, {31'h0, imem.req}, {31'h0, !bad_addr(PC_F)});
                check({tag, ".addr"}, imem.addr, PC_F);
            end
            @(posedge clk);
            #1;
            cyc++;
            gap++;
            if (adv) begin
                e = sb.pop_front();
                check({tag, ".pc_d"}, PC_D, e.pc);
                check({tag, ".instr"}, Instr_D, e.instr);
                check({tag, ".exc"}, {31'h0, ExcAdEL_D}, {31'h0, e.exc});
                check({tag, ".gap"}, gap, gap_exp);
                gap = 0;
            end
        end
        if (sb.size() > 0) begin
            check({tag, ".timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        reset = 1'b1;
        Stall = 1'b0;

        // 1: zero-wait ROM
        lat = 0;
        chk_req = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) push_ok(32'h3000 + 32'(4 * i));
        run("t1", 1, 20);
        check("t1.busy", {31'h0, Fetch_Busy}, 32'h0);
        chk_req = 1'b0;

        // 2: latency 2
        lat = 2;
        do_reset();
        for (int i = 0; i < 4; i++) push_ok(32'h3000 + 32'(4 * i));
        run("t2", 3, 40);

        // 3: response during a 3-cycle stall, stray valid in HOLD
        lat = 1;
        Stall = 1'b1;
        do_reset();
        @(posedge clk);
        #1;
        check("t3.resp_busy", {31'h0, Fetch_Busy}, 32'h0);
        check("t3.resp_req", {31'h0, imem.req}, 32'h1);
        @(posedge clk);
        #1;
        stray = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("t3.hold_req", {31'h0, imem.req}, 32'h0);
            check("t3.hold_pcf", PC_F, 32'h3000);
            check("t3.hold_instr", Instr_D, 32'h0);
            check("t3.hold_busy", {31'h0, Fetch_Busy}, 32'h0);
            @(posedge clk);
            #1;
        end
        stray = 1'b0;
        Stall = 1'b0;
        push_ok(32'h3000);
        run("t3a", 1, 10);
        check("t3.next_addr", imem.addr, 32'h3004);
        check("t3.next_req", {31'h0, imem.req}, 32'h1);
        push_ok(32'h3004);
        run("t3b", 2, 10);

        // 4: taken beq at 3000 -> 3100, delay slot 3004
        br_en = 1'b1;
        lat = 0;
        do_reset();
        push_ok(32'h3000);
        push_ok(32'h3004);
        push_ok(32'h3100);
        push_ok(32'h3104);
        run("t4z", 1, 20);
        lat = 3;
        do_reset();
        push_ok(32'h3000);
        push_ok(32'h3004);
        push_ok(32'h3100);
        push_ok(32'h3104);
        run("t4l", 4, 40);
        br_en = 1'b0;

        // 5: misaligned and out-of-window fetches
        bad_en = 1'b1;
        chk_req = 1'b1;
        lat = 0;
        do_reset();
        push_ok(32'h3000);
        push_bad(32'h3002);
        push_bad(32'h8000);
        push_ok(32'h3000);
        push_bad(32'h3002);
        run("t5", 1, 20);
        bad_en = 1'b0;
        chk_req = 1'b0;

        // 6: async reset in the middle of a latency-3 wait
        lat = 3;
        do_reset();
        push_ok(32'h3000);
        push_ok(32'h3004);
        run("t6a", 4, 20);
        @(posedge clk);
        #2;
        check("t6.pre_pcf", PC_F, 32'h3008);
        reset = 1'b1;
        #1;
        check("t6.pc_f", PC_F, 32'h3000);
        check("t6.pc_d", PC_D, 32'h3000);
        check("t6.instr", Instr_D, 32'h0);
        check("t6.exc", {31'h0, ExcAdEL_D}, 32'h0);
        check("t6.busy", {31'h0, Fetch_Busy}, 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        push_ok(32'h3000);
        push_ok(32'h3004);
        run("t6b", 4, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
